// File: rtl/interface_hcsr04.sv
// ---------------------------------------------------------------------------
// interface_hcsr04
//   Front end for an HC-SR04 ultrasonic ranger. A rising edge on medir fires
//   one trigger pulse, the returning echo pulse is timed and converted to
//   centimetres (rounded to nearest), and the result is presented as 3-digit
//   BCD on medida together with a one-cycle pronto pulse. A missing echo, or
//   an echo that stays high too long, ends the measurement with timeout=1
//   and leaves medida untouched.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   synchronous, active-high
//   medir      in   measure request, rising edge starts a measurement
//   echo       in   asynchronous echo line from the sensor
//   trigger    out  sensor trigger pulse (registered)
//   medida     out  distance in BCD {centena, dezena, unidade}, 0..999
//   pronto     out  one-cycle pulse: measurement finished (valid or timeout)
//   timeout    out  last measurement timed out; cleared at the next start
//   db_estado  out  current FSM state code
//
// Handshake: medida, timeout and pronto are produced together; a consumer
// samples medida/timeout on the single cycle pronto is high. There is no
// backpressure: the result register holds until the next armazena.
// ---------------------------------------------------------------------------
module interface_hcsr04 #(
    parameter int TRIGGER_CICLOS = 500,
    parameter int CICLOS_CM      = 2941,
    parameter int MEIO_CM        = 1470,
    parameter int TIMEOUT_CICLOS = 2500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo,
    output logic        trigger,
    output logic [11:0] medida,
    output logic        pronto,
    output logic        timeout,
    output logic [3:0]  db_estado
);

    localparam int TICK_W = $clog2(CICLOS_CM + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CICLOS + 1);
    localparam int TRG_W  = $clog2(TRIGGER_CICLOS + 1);

    typedef enum logic [3:0] {
        INICIAL       = 4'd0,
        PREPARACAO    = 4'd1,
        ENVIA_TRIGGER = 4'd2,
        ESPERA_ECHO   = 4'd3,
        MEDIDA_ST     = 4'd4,
        ARREDONDA     = 4'd5,
        ARMAZENA      = 4'd6,
        FINAL_MEDIDA  = 4'd7,
        ERRO          = 4'd8
    } estado_t;

    estado_t           r_estado;
    logic              r_medir_q;
    logic              r_echo_m;
    logic              r_echo_s;
    logic [TICK_W-1:0] r_tick;
    logic [11:0]       r_bcd;
    logic [TMO_W-1:0]  r_tmo;
    logic [TRG_W-1:0]  r_trig_cnt;
    logic              r_trigger;
    logic [11:0]       r_medida;
    logic              r_pronto;
    logic              r_timeout;

    logic              w_start;
    logic              w_tick_wrap;
    logic [TICK_W-1:0] w_tick_next;
    logic [11:0]       w_bcd_next;
    logic              w_tmo_fim;

    // BCD +1 with decimal carry, saturating at 999.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] u;
        c = v[11:8];
        d = v[7:4];
        u = v[3:0];
        if (v == 12'h999) begin
            return v;
        end
        if (u != 4'd9) begin
            u = u + 4'd1;
        end else begin
            u = 4'd0;
            if (d != 4'd9) begin
                d = d + 4'd1;
            end else begin
                d = 4'd0;
                c = c + 4'd1;
            end
        end
        return {c, d, u};
    endfunction

    assign w_start = medir & ~r_medir_q;

    // One echo-high cycle worth of counting: tick runs modulo CICLOS_CM and
    // each wrap adds one centimetre. The tick keeps running at saturation.
    always_comb begin
        w_tick_wrap = (r_tick == TICK_W'(CICLOS_CM - 1));
        w_tick_next = w_tick_wrap ? '0 : r_tick + TICK_W'(1);
        w_bcd_next  = w_tick_wrap ? bcd_inc(r_bcd) : r_bcd;
        w_tmo_fim   = (r_tmo == TMO_W'(TIMEOUT_CICLOS - 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= INICIAL;
            r_medir_q  <= 1'b0;
            r_echo_m   <= 1'b0;
            r_echo_s   <= 1'b0;
            r_tick     <= '0;
            r_bcd      <= 12'h000;
            r_tmo      <= '0;
            r_trig_cnt <= '0;
            r_trigger  <= 1'b0;
            r_medida   <= 12'h000;
            r_pronto   <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_medir_q <= medir;
            // Both echo edges see the same two-flop delay, so the width of
            // echo_s equals the width of the pin pulse.
            r_echo_m  <= echo;
            r_echo_s  <= r_echo_m;

            case (r_estado)
                INICIAL: begin
                    if (w_start) begin
                        r_estado <= PREPARACAO;
                    end
                end
                PREPARACAO: begin
                    r_tick     <= '0;
                    r_bcd      <= 12'h000;
                    r_tmo      <= '0;
                    r_trig_cnt <= '0;
                    r_timeout  <= 1'b0;
                    r_trigger  <= 1'b1;
                    r_estado   <= ENVIA_TRIGGER;
                end
                ENVIA_TRIGGER: begin
                    // trigger went high on entry; it stays high for exactly
                    // TRIGGER_CICLOS cycles of this state.
                    if (r_trig_cnt == TRG_W'(TRIGGER_CICLOS - 1)) begin
                        r_trigger <= 1'b0;
                        r_estado  <= ESPERA_ECHO;
                    end else begin
                        r_trig_cnt <= r_trig_cnt + TRG_W'(1);
                    end
                end
                ESPERA_ECHO: begin
                    if (r_echo_s) begin
                        // The first high sample already counts toward the width.
                        r_tick   <= w_tick_next;
                        r_bcd    <= w_bcd_next;
                        r_tmo    <= '0;
                        r_estado <= MEDIDA_ST;
                    end else if (w_tmo_fim) begin
                        r_timeout <= 1'b1;
                        r_pronto  <= 1'b1;
                        r_estado  <= ERRO;
                    end else begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                MEDIDA_ST: begin
                    if (!r_echo_s) begin
                        r_estado <= ARREDONDA;
                    end else if (w_tmo_fim) begin
                        r_timeout <= 1'b1;
                        r_pronto  <= 1'b1;
                        r_estado  <= ERRO;
                    end else begin
                        r_tick <= w_tick_next;
                        r_bcd  <= w_bcd_next;
                        r_tmo  <= r_tmo + TMO_W'(1);
                    end
                end
                ARREDONDA: begin
                    if ((r_tick >= TICK_W'(MEIO_CM)) && (r_bcd != 12'h999)) begin
                        r_bcd <= bcd_inc(r_bcd);
                    end
                    r_estado <= ARMAZENA;
                end
                ARMAZENA: begin
                    r_medida <= r_bcd;
                    r_pronto <= 1'b1;
                    r_estado <= FINAL_MEDIDA;
                end
                FINAL_MEDIDA: begin
                    r_pronto <= 1'b0;
                    r_estado <= INICIAL;
                end
                ERRO: begin
                    r_pronto <= 1'b0;
                    r_estado <= INICIAL;
                end
                default: begin
                    r_estado <= INICIAL;
                end
            endcase
        end
    end

    assign trigger   = r_trigger;
    assign medida    = r_medida;
    assign pronto    = r_pronto;
    assign timeout   = r_timeout;
    assign db_estado = r_estado;

endmodule

// File: tb/tb_interface_hcsr04.sv
// ---------------------------------------------------------------------------
// tb_interface_hcsr04
//   Self-checking bench for interface_hcsr04 with scaled-down timing
//   parameters. Expected distances come from a plain arithmetic model
//   (floor division plus a round-up on the residual, saturated at 999).
// ---------------------------------------------------------------------------
module tb_interface_hcsr04;

    localparam int TRIG = 10;
    localparam int CM   = 29;
    localparam int MEIO = 14;
    localparam int TMO  = 4000;

    logic        clock = 1'b0;
    logic        reset;
    logic        medir;
    logic        echo;
    logic        trigger;
    logic [11:0] medida;
    logic        pronto;
    logic        timeout;
    logic [3:0]  db_estado;

    int n_vec  = 0;
    int n_fail = 0;

    int trig_pulses = 0;
    int trig_len    = 0;
    int trig_cur    = 0;

    logic [11:0] last_medida = 12'h000;

    always #5 clock = ~clock;

    interface_hcsr04 #(
        .TRIGGER_CICLOS(TRIG),
        .CICLOS_CM     (CM),
        .MEIO_CM       (MEIO),
        .TIMEOUT_CICLOS(TMO)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .medir    (medir),
        .echo     (echo),
        .trigger  (trigger),
        .medida   (medida),
        .pronto   (pronto),
        .timeout  (timeout),
        .db_estado(db_estado)
    );

    // Trigger pulse monitor: counts pulses and records the length of the last one.
    always @(negedge clock) begin
        if (trigger === 1'b1) begin
            trig_cur = trig_cur + 1;
        end else if (trig_cur > 0) begin
            trig_len    = trig_cur;
            trig_pulses = trig_pulses + 1;
            trig_cur    = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: round-to-nearest centimetres, saturated at 999, as BCD.
    function automatic logic [11:0] ref_cm(input int w);
        int cm;
        cm = w / CM;
        if ((w % CM) >= MEIO) cm = cm + 1;
        if (cm > 999) cm = 999;
        return {4'(cm / 100), 4'((cm / 10) % 10), 4'(cm % 10)};
    endfunction

    // width == 0 means no echo at all (timeout path).
    task automatic measure(input int width, input int delay, input int hold,
                           input bit extra_edge, input string tag);
        int p0;
        int n;
        p0 = trig_pulses;
        fork
            begin
                medir = 1'b1;
                repeat (hold) @(negedge clock);
                medir = 1'b0;
            end
        join_none

        n = 0;
        while (trigger !== 1'b1 && n < 100) begin @(negedge clock); n++; end
        check({tag, " trig_rise"}, 32'(n < 100), 32'd1);
        n = 0;
        while (trigger === 1'b1 && n < TRIG + 100) begin @(negedge clock); n++; end
        check({tag, " trig_fall"}, 32'(n < TRIG + 100), 32'd1);
        @(negedge clock);
        check({tag, " trig_len"}, 32'(trig_len), 32'(TRIG));
        check({tag, " wait_state"}, 32'(db_estado), 32'd3);

        if (extra_edge) begin
            medir = 1'b1;
            repeat (3) @(negedge clock);
            medir = 1'b0;
        end
        repeat (delay) @(negedge clock);

        if (width > 0) begin
            echo = 1'b1;
            repeat (width) @(negedge clock);
            echo = 1'b0;
            n = 0;
            while (pronto !== 1'b1 && n < 20) begin @(negedge clock); n++; end
            check({tag, " latency"}, 32'(n), 32'd5);
            last_medida = ref_cm(width);
            check({tag, " medida"}, 32'(medida), 32'(last_medida));
            check({tag, " timeout"}, 32'(timeout), 32'd0);
            check({tag, " final_state"}, 32'(db_estado), 32'd7);
        end else begin
            n = 0;
            while (pronto !== 1'b1 && n < TMO + 100) begin @(negedge clock); n++; end
            check({tag, " tmo_pronto"}, 32'(n < TMO + 100), 32'd1);
            check({tag, " tmo_flag"}, 32'(timeout), 32'd1);
            check({tag, " tmo_medida"}, 32'(medida), 32'(last_medida));
            check({tag, " erro_state"}, 32'(db_estado), 32'd8);
        end

        @(negedge clock);
        check({tag, " pronto_1cyc"}, 32'(pronto), 32'd0);
        check({tag, " idle_state"}, 32'(db_estado), 32'd0);

        n = 0;
        while (medir !== 1'b0 && n < 2000) begin @(negedge clock); n++; end
        repeat (5) @(negedge clock);
        check({tag, " trig_pulses"}, 32'(trig_pulses), 32'(p0 + 1));
        check({tag, " idle_after"}, 32'(db_estado), 32'd0);
    endtask

    initial begin
        int n;
        int w;
        reset = 1'b1;
        medir = 1'b0;
        echo  = 1'b0;
        repeat (100) @(negedge clock);
        reset = 1'b0;
        repeat (100) @(negedge clock);
        check("rst trigger", 32'(trigger), 32'd0);
        check("rst medida", 32'(medida), 32'h000);
        check("rst pronto", 32'(pronto), 32'd0);
        check("rst timeout", 32'(timeout), 32'd0);
        check("rst state", 32'(db_estado), 32'd0);

        measure(100 * CM, 40, 5, 1'b0, "m100");
        measure(100 * CM + MEIO - 1, 40, 5, 1'b0, "m100_trunc");
        measure(74 * CM + 10, 30, 5, 1'b0, "m074");
        measure(74 * CM + MEIO, 30, 5, 1'b0, "m075");
        measure(10 * CM + MEIO - 1, 20, 5, 1'b0, "m010");
        measure(10 * CM + MEIO, 20, 5, 1'b0, "m011");
        measure(MEIO - 1, 20, 5, 1'b0, "m000");
        measure(20 * CM, 20, 5, 1'b0, "m020_exact");
        measure(1, 20, 5, 1'b0, "m_w1");
        measure(74 * CM + MEIO + 5, 30, 5, 1'b0, "m075b");
        measure(0, 0, 5, 1'b0, "tmo");
        measure(100 * CM, 40, 5, 1'b1, "m100_2nd_edge");
        measure(33 * CM + 7, 20, 1000, 1'b0, "hold1000");

        for (int i = 0; i < 6; i++) begin
            w = $urandom_range(130 * CM, 1);
            measure(w, $urandom_range(60, 1), $urandom_range(8, 1), 1'b0, "rand");
        end

        // Reset in the middle of an echo measurement.
        medir = 1'b1;
        repeat (3) @(negedge clock);
        medir = 1'b0;
        n = 0;
        while (trigger !== 1'b1 && n < 100) begin @(negedge clock); n++; end
        while (trigger === 1'b1 && n < TRIG + 200) begin @(negedge clock); n++; end
        echo = 1'b1;
        repeat (50) @(negedge clock);
        check("mid measuring_state", 32'(db_estado), 32'd4);
        reset = 1'b1;
        @(negedge clock);
        check("mid rst state", 32'(db_estado), 32'd0);
        check("mid rst trigger", 32'(trigger), 32'd0);
        check("mid rst medida", 32'(medida), 32'h000);
        check("mid rst pronto", 32'(pronto), 32'd0);
        reset = 1'b0;
        echo  = 1'b0;
        last_medida = 12'h000;
        repeat (10) @(negedge clock);
        check("mid idle", 32'(db_estado), 32'd0);
        measure(42 * CM + 20, 20, 5, 1'b0, "after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
